// File: rtl/coin_pkg.sv
// Shared types and helpers for the coin/enemy/block managers.
// Coordinates are 10-bit screen positions; overlap math widens to 11 bits.
package coin_pkg;
  localparam int COORD_W = 10;

  typedef enum logic {IDLE, SCAN} scan_state_e;

  // Strict AABB overlap; sums carried in COORD_W+1 bits so x near 1023 never wraps.
  function automatic logic hit(input logic [COORD_W-1:0] px, py, cx, cy,
                               input logic [COORD_W:0]   w, h);
    logic [COORD_W:0] px1, py1, cx1, cy1;
    px1 = {1'b0, px};
    py1 = {1'b0, py};
    cx1 = {1'b0, cx};
    cy1 = {1'b0, cy};
    return (py1 < cy1 + h) && (cy1 < py1 + h) &&
           (px1 < cx1 + w) && (cx1 < px1 + w);
  endfunction
endpackage

// File: rtl/frame_tick_detect.sv
// Brings the slow frame strobe into the Clk domain and emits a one-cycle
// tick on its rising edge.
module frame_tick_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_frame,
  output logic o_tick
);
  logic r_s1, r_s2, r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_frame;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_tick = r_s2 & ~r_prev;
endmodule

// File: rtl/coin_bank.sv
// Per-frame coin scanner: visits one coin per Clk, credits the colliding
// player with a saturating score and respawns coins after a frame count.
module coin_bank
  import coin_pkg::*;
#(
  parameter int NUM_COINS      = 8,
  parameter int PLAYER_W       = 16,
  parameter int PLAYER_H       = 28,
  parameter int RESPAWN_FRAMES = 120,
  parameter int SCORE_W        = 8
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic                                      i_frame_clk,
  input  logic                                      i_coin_reset,
  input  logic [COORD_W-1:0]                        i_mario_x,
  input  logic [COORD_W-1:0]                        i_mario_y,
  input  logic [COORD_W-1:0]                        i_luigi_x,
  input  logic [COORD_W-1:0]                        i_luigi_y,
  input  logic [COORD_W*NUM_COINS-1:0]              i_coin_x,
  input  logic [COORD_W*NUM_COINS-1:0]              i_coin_y,
  output logic [NUM_COINS-1:0]                      o_coin_alive,
  output logic [SCORE_W-1:0]                        o_mario_score,
  output logic [SCORE_W-1:0]                        o_luigi_score,
  output logic                                      o_collect_pulse,
  output logic [$clog2(NUM_COINS > 1 ? NUM_COINS : 2)-1:0] o_collect_idx,
  output logic                                      o_collect_by_luigi,
  output logic                                      o_busy
);
  localparam int IW = $clog2(NUM_COINS > 1 ? NUM_COINS : 2);
  localparam int TW = $clog2(RESPAWN_FRAMES > 0 ? RESPAWN_FRAMES + 1 : 2);
  localparam logic [TW-1:0]      RESP_LD  = TW'(RESPAWN_FRAMES);
  localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_COINS - 1);
  localparam logic [COORD_W:0]   HIT_W    = (COORD_W+1)'(PLAYER_W);
  localparam logic [COORD_W:0]   HIT_H    = (COORD_W+1)'(PLAYER_H);

  scan_state_e          r_state;
  logic [IW-1:0]        r_idx;
  logic                 r_pending;
  logic                 r_busy;
  logic [NUM_COINS-1:0] r_alive;
  logic [TW-1:0]        r_timer [NUM_COINS];
  logic [SCORE_W-1:0]   r_mscore, r_lscore;
  logic                 r_pulse;
  logic [IW-1:0]        r_cidx;
  logic                 r_by_luigi;

  logic                 w_tick;
  logic [COORD_W-1:0]   w_cx, w_cy;
  logic                 w_hit_m, w_hit_l;
  logic [TW-1:0]        w_tmr;

  frame_tick_detect u_tick (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_frame (i_frame_clk),
    .o_tick  (w_tick)
  );

  assign w_cx    = i_coin_x[int'(r_idx)*COORD_W +: COORD_W];
  assign w_cy    = i_coin_y[int'(r_idx)*COORD_W +: COORD_W];
  assign w_hit_m = hit(i_mario_x, i_mario_y, w_cx, w_cy, HIT_W, HIT_H);
  assign w_hit_l = hit(i_luigi_x, i_luigi_y, w_cx, w_cy, HIT_W, HIT_H);
  assign w_tmr   = r_timer[r_idx];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_busy     <= 1'b0;
      r_alive    <= '1;
      for (int i = 0; i < NUM_COINS; i++) r_timer[i] <= '0;
      r_mscore   <= '0;
      r_lscore   <= '0;
      r_pulse    <= 1'b0;
      r_cidx     <= '0;
      r_by_luigi <= 1'b0;
    end else if (i_coin_reset) begin
      // Level restart: scores survive, any tick seen this cycle is dropped.
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_alive   <= '1;
      for (int i = 0; i < NUM_COINS; i++) r_timer[i] <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= SCAN;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (r_alive[r_idx]) begin
            if (w_hit_m || w_hit_l) begin
              r_alive[r_idx] <= 1'b0;
              r_timer[r_idx] <= RESP_LD;
              r_pulse        <= 1'b1;
              r_cidx         <= r_idx;
              r_by_luigi     <= ~w_hit_m;
              if (w_hit_m) begin
                if (r_mscore != '1) r_mscore <= r_mscore + 1'b1;
              end else begin
                if (r_lscore != '1) r_lscore <= r_lscore + 1'b1;
              end
            end
          end else if (w_tmr > TW'(1)) begin
            r_timer[r_idx] <= w_tmr - 1'b1;
          end else if (w_tmr == TW'(1)) begin
            r_timer[r_idx] <= '0;
            r_alive[r_idx] <= 1'b1;
          end

          if (r_idx == LAST_IDX) begin
            r_idx <= '0;
            // Ticks that landed mid-scan collapse into one back-to-back rescan.
            if (r_pending || w_tick) begin
              r_pending <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
            if (w_tick) r_pending <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_coin_alive       = r_alive;
  assign o_mario_score      = r_mscore;
  assign o_luigi_score      = r_lscore;
  assign o_collect_pulse    = r_pulse;
  assign o_collect_idx      = r_cidx;
  assign o_collect_by_luigi = r_by_luigi;
  assign o_busy             = r_busy;
endmodule

// File: tb/tb_coin_bank.sv
// Bench for coin_bank: two instances (default, and fast-respawn/2-bit score)
// share stimulus and are checked against a frame-level reference model.
module tb_coin_bank;
  logic clk = 1'b0;
  logic rst, frame, crst;
  logic [9:0] mx, my, lx, ly;
  logic [79:0] cxp, cyp;
  int cx [8];
  int cy [8];

  logic [7:0] alive_a, alive_b;
  logic [7:0] ms_a, ls_a;
  logic [1:0] ms_b, ls_b;
  logic pa, pb, ba, bb, busy_a, busy_b;
  logic [2:0] ia, ib;

  int nchk = 0;
  int nerr = 0;
  int bca, bcb;
  logic [3:0] qa[$], qb[$], eqa[$], eqb[$];

  int m_alive [2][8];
  int m_tmr   [2][8];
  int m_ms [2];
  int m_ls [2];

  always #5 clk = ~clk;

  coin_bank dut_a (
    .i_clk(clk), .i_reset(rst), .i_frame_clk(frame), .i_coin_reset(crst),
    .i_mario_x(mx), .i_mario_y(my), .i_luigi_x(lx), .i_luigi_y(ly),
    .i_coin_x(cxp), .i_coin_y(cyp), .o_coin_alive(alive_a),
    .o_mario_score(ms_a), .o_luigi_score(ls_a), .o_collect_pulse(pa),
    .o_collect_idx(ia), .o_collect_by_luigi(ba), .o_busy(busy_a));

  coin_bank #(.RESPAWN_FRAMES(3), .SCORE_W(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_frame_clk(frame), .i_coin_reset(crst),
    .i_mario_x(mx), .i_mario_y(my), .i_luigi_x(lx), .i_luigi_y(ly),
    .i_coin_x(cxp), .i_coin_y(cyp), .o_coin_alive(alive_b),
    .o_mario_score(ms_b), .o_luigi_score(ls_b), .o_collect_pulse(pb),
    .o_collect_idx(ib), .o_collect_by_luigi(bb), .o_busy(busy_b));

  always @(negedge clk) begin
    if (pa === 1'b1) qa.push_back({ia, ba});
    if (pb === 1'b1) qb.push_back({ib, bb});
    if (busy_a === 1'b1) bca++;
    if (busy_b === 1'b1) bcb++;
  end

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pack_coins;
    for (int i = 0; i < 8; i++) begin
      cxp[i*10 +: 10] = 10'(cx[i]);
      cyp[i*10 +: 10] = 10'(cy[i]);
    end
  endtask

  task automatic default_coins;
    for (int i = 0; i < 8; i++) begin
      cx[i] = 100 + 20*i;
      cy[i] = 200;
    end
    pack_coins();
  endtask

  task automatic model_restart;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        m_alive[d][i] = 1;
        m_tmr[d][i]   = 0;
      end
  endtask

  function automatic bit ov(int px, int py, int qx, int qy);
    int dx, dy;
    dx = px - qx; if (dx < 0) dx = -dx;
    dy = py - qy; if (dy < 0) dy = -dy;
    return (dx < 16) && (dy < 28);
  endfunction

  // One full pass over the coins at frame granularity.
  task automatic model_scan(input int d);
    int resp, smax;
    bit hm, hl;
    resp = (d == 0) ? 120 : 3;
    smax = (d == 0) ? 255 : 3;
    for (int i = 0; i < 8; i++) begin
      hm = ov(int'(mx), int'(my), cx[i], cy[i]);
      hl = ov(int'(lx), int'(ly), cx[i], cy[i]);
      if (m_alive[d][i] != 0) begin
        if (hm || hl) begin
          m_alive[d][i] = 0;
          m_tmr[d][i]   = resp;
          if (hm) m_ms[d] = (m_ms[d] < smax) ? m_ms[d] + 1 : smax;
          else    m_ls[d] = (m_ls[d] < smax) ? m_ls[d] + 1 : smax;
          if (d == 0) eqa.push_back({3'(i), ~hm});
          else        eqb.push_back({3'(i), ~hm});
        end
      end else if (m_tmr[d][i] > 0) begin
        m_tmr[d][i]--;
        if (m_tmr[d][i] == 0) m_alive[d][i] = 1;
      end
    end
  endtask

  function automatic logic [7:0] m_vec(int d);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (m_alive[d][i] != 0);
    return v;
  endfunction

  task automatic compare_model(input string tag);
    chk({tag, " alive_a"}, alive_a, m_vec(0));
    chk({tag, " alive_b"}, alive_b, m_vec(1));
    chk({tag, " mscore_a"}, ms_a, m_ms[0]);
    chk({tag, " lscore_a"}, ls_a, m_ls[0]);
    chk({tag, " mscore_b"}, ms_b, m_ms[1]);
    chk({tag, " lscore_b"}, ls_b, m_ls[1]);
    chk({tag, " npulse_a"}, qa.size(), eqa.size());
    chk({tag, " npulse_b"}, qb.size(), eqb.size());
    for (int i = 0; i < qa.size() && i < eqa.size(); i++)
      chk($sformatf("%s pulse_a[%0d]", tag, i), qa[i], eqa[i]);
    for (int i = 0; i < qb.size() && i < eqb.size(); i++)
      chk($sformatf("%s pulse_b[%0d]", tag, i), qb[i], eqb[i]);
  endtask

  task automatic clear_logs;
    qa.delete(); qb.delete(); eqa.delete(); eqb.delete();
    bca = 0; bcb = 0;
  endtask

  // Single tick from idle; 16 cycles cover sync, 8 visits and the last pulse.
  task automatic run_frame(input string tag);
    clear_logs();
    frame = 1'b1;
    repeat (3) cyc();
    frame = 1'b0;
    repeat (13) cyc();
    model_scan(0);
    model_scan(1);
    compare_model(tag);
    chk({tag, " busy_cycles_a"}, bca, 8);
    chk({tag, " busy_cycles_b"}, bcb, 8);
  endtask

  task automatic rand_player(output logic [9:0] x, output logic [9:0] y);
    int k;
    if ($urandom_range(0, 3) != 0) begin
      k = $urandom_range(0, 7);
      x = 10'(100 + 20*k + int'($urandom_range(0, 36)) - 18);
      y = 10'(200 + int'($urandom_range(0, 60)) - 30);
    end else begin
      x = 10'($urandom_range(0, 1023));
      y = 10'($urandom_range(0, 1023));
    end
  endtask

  typedef struct {
    logic [9:0] mx, my, lx, ly, c4x;
    logic [7:0] alive, ms, ls;
    int np;
    logic [2:0] eidx;
  } vec_t;

  vec_t tbl [9];
  int exp_b0 [5];
  int exp_pb [5];
  logic [7:0] fpat;

  initial begin
    tbl[0] = '{10'd0,    10'd0,   10'd0,    10'd0,   10'd180,  8'hFF, 8'd0, 8'd0, 0, 3'd0};
    tbl[1] = '{10'd140,  10'd200, 10'd0,    10'd0,   10'd180,  8'hFB, 8'd1, 8'd0, 1, 3'd2};
    tbl[2] = '{10'd200,  10'd200, 10'd200,  10'd200, 10'd180,  8'hDB, 8'd2, 8'd0, 1, 3'd5};
    tbl[3] = '{10'd0,    10'd0,   10'd240,  10'd210, 10'd180,  8'h5B, 8'd2, 8'd1, 1, 3'd7};
    tbl[4] = '{10'd236,  10'd200, 10'd0,    10'd0,   10'd180,  8'h5B, 8'd2, 8'd1, 0, 3'd0};
    tbl[5] = '{10'd100,  10'd228, 10'd0,    10'd0,   10'd180,  8'h5B, 8'd2, 8'd1, 0, 3'd0};
    tbl[6] = '{10'd100,  10'd227, 10'd0,    10'd0,   10'd180,  8'h5A, 8'd3, 8'd1, 1, 3'd0};
    tbl[7] = '{10'd1010, 10'd200, 10'd0,    10'd0,   10'd1020, 8'h4A, 8'd4, 8'd1, 1, 3'd4};
    tbl[8] = '{10'd0,    10'd0,   10'd1020, 10'd200, 10'd1020, 8'h4A, 8'd4, 8'd1, 0, 3'd0};
    exp_b0 = '{0, 0, 0, 1, 0};
    exp_pb = '{1, 0, 0, 0, 1};

    rst = 1'b1; frame = 1'b0; crst = 1'b0;
    mx = '0; my = '0; lx = '0; ly = '0;
    default_coins();
    clear_logs();
    repeat (3) cyc();
    chk("reset alive_a", alive_a, 8'hFF);
    chk("reset alive_b", alive_b, 8'hFF);
    chk("reset mscore_a", ms_a, 0);
    chk("reset lscore_a", ls_a, 0);
    chk("reset pulse_a", pa, 0);
    chk("reset idx_a", ia, 0);
    chk("reset by_a", ba, 0);
    chk("reset busy_a", busy_a, 0);
    chk("reset busy_b", busy_b, 0);
    rst = 1'b0;
    model_restart();
    m_ms = '{0, 0}; m_ls = '{0, 0};
    cyc();

    for (int v = 0; v < 9; v++) begin
      mx = tbl[v].mx; my = tbl[v].my; lx = tbl[v].lx; ly = tbl[v].ly;
      cx[4] = int'(tbl[v].c4x);
      pack_coins();
      run_frame($sformatf("vec%0d", v));
      chk($sformatf("vec%0d tbl_alive", v), alive_a, tbl[v].alive);
      chk($sformatf("vec%0d tbl_mscore", v), ms_a, tbl[v].ms);
      chk($sformatf("vec%0d tbl_lscore", v), ls_a, tbl[v].ls);
      chk($sformatf("vec%0d tbl_npulse", v), qa.size(), tbl[v].np);
      if (tbl[v].np == 1 && qa.size() == 1)
        chk($sformatf("vec%0d tbl_idx_by", v), qa[0], {tbl[v].eidx, tbl[v].lx == 10'd240 ? 1'b1 : 1'b0});
    end
    default_coins();

    // coin_reset mid-scan, landing on the visit of a collectable coin.
    crst = 1'b1; cyc(); crst = 1'b0; cyc();
    model_restart();
    chk("crst alive_a", alive_a, 8'hFF);
    chk("crst alive_b", alive_b, 8'hFF);
    clear_logs();
    mx = 10'd140; my = 10'd200; lx = '0; ly = '0;
    frame = 1'b1;
    repeat (4) cyc();
    chk("crst midscan busy", busy_a, 1);
    cyc();
    crst = 1'b1;
    cyc();
    crst = 1'b0;
    chk("crst busy_a", busy_a, 0);
    chk("crst busy_b", busy_b, 0);
    chk("crst pulse", pa, 0);
    chk("crst alive_a2", alive_a, 8'hFF);
    chk("crst mscore_a", ms_a, m_ms[0]);
    chk("crst mscore_b", ms_b, m_ms[1]);
    frame = 1'b0;
    repeat (10) cyc();
    chk("crst no pulses", qa.size() + qb.size(), 0);
    chk("crst idle", busy_a, 0);

    // Respawn after three frames; a camping player must wait one more frame.
    crst = 1'b1; cyc(); crst = 1'b0; cyc();
    model_restart();
    mx = 10'd100; my = 10'd200;
    for (int f = 0; f < 5; f++) begin
      run_frame($sformatf("resp%0d", f));
      chk($sformatf("resp%0d alive_b0", f), alive_b[0], exp_b0[f]);
      chk($sformatf("resp%0d npulse_b", f), qb.size(), exp_pb[f]);
      chk($sformatf("resp%0d alive_a0", f), alive_a[0], 0);
    end
    chk("sat mscore_b", ms_b, 3);

    // Two ticks inside one scan fold into exactly one extra scan.
    mx = '0; my = '0; lx = '0; ly = '0;
    clear_logs();
    fpat = 8'b0100_1001;
    for (int c = 0; c < 8; c++) begin
      frame = fpat[c];
      cyc();
    end
    frame = 1'b0;
    repeat (30) cyc();
    for (int s = 0; s < 2; s++) begin
      model_scan(0);
      model_scan(1);
    end
    compare_model("dbl");
    chk("dbl busy_cycles_a", bca, 16);
    chk("dbl busy_cycles_b", bcb, 16);

    for (int r = 0; r < 40; r++) begin
      rand_player(mx, my);
      rand_player(lx, ly);
      run_frame($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
